rc4_keysearch_ctrl: RTL and testbench
=====================================

Name: rc4_keysearch_ctrl

Overview:
- Parametrised successor to the single-core brute-force key counter.
- Dispatches candidate secret keys from a programmable inclusive range [key_lo, key_hi] to N_CORES independent RC4 init/shuffle/decrypt pipelines.
- Collects each core's finish/valid result and reports the first key that decrypts to a valid message, or reports exhaustion of the range.
- Sits between the board-level start/switch logic and the per-core memory FSM chains.

Parameters:
- KEY_W, 24, width of candidate secret key.
- N_CORES, 4, number of parallel decrypt cores; range 1..16.
- IDX_W, 2, width of core index; 2**IDX_W >= N_CORES is required.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  synchronous, active-low reset.
- start  in  1  pulse; latches key_lo/key_hi and begins search; honoured only when not busy.
- abort  in  1  pulse; stops search, returns to IDLE.
- key_lo  in  KEY_W  first candidate key.
- key_hi  in  KEY_W  last candidate key, inclusive.
- core_key  out  N_CORES*KEY_W  key for core c at [c*KEY_W +: KEY_W]; held until that core's next assignment.
- core_restart  out  N_CORES  one-cycle pulse; core c restarts its chain with core_key slice c.
- core_done  in  N_CORES  one-cycle finish pulse from core c.
- core_valid  in  N_CORES  sampled only together with core_done[c].
- busy  out  1  high in RUN.
- solved  out  1  sticky until start, abort or reset.
- exhausted  out  1  sticky until start, abort or reset.
- found_key  out  KEY_W  winning key; valid while solved=1.
- found_core  out  IDX_W  index of the winning core.
- keys_tried  out  KEY_W+1  number of completed (done) trials since start.

Behaviour:
- All outputs are registered.
- Reset (reset_n=0 at a clock edge):
  - state=IDLE.
  - All outputs 0, including core_key and core_restart.
  - Per-core busy flags cleared.
  - Reset takes effect mid-run without draining.
- States: IDLE, RUN, SOLVED, EXHAUSTED.
- start in IDLE/SOLVED/EXHAUSTED at edge t:
  - Latch lo/hi.
  - Clear solved, exhausted and keys_tried.
  - next_key (KEY_W+1 bits) = lo.
  - If lo>hi: go to EXHAUSTED at t+1 with no dispatch.
  - Otherwise go to RUN at t+1.
- start while in RUN is ignored.
- Dispatch in RUN:
  - At most one assignment per cycle, to the lowest-index idle core, and only if next_key <= hi.
  - The assignment drives core_restart[c]=1 and core_key[c]=next_key in the same registered cycle.
  - It also marks core c busy and increments next_key.
  - First pulse is core_restart[0] with key lo, in cycle t+1 after start.
  - next_key is KEY_W+1 wide, so hi = all-ones never wraps.
- Completion:
  - core_done[c] on a busy core clears its busy flag; the core becomes eligible for dispatch the following cycle, not the same cycle.
  - keys_tried increments by the popcount of accepted dones in that cycle.
  - core_done on a non-busy core is ignored and not counted.
- Solve:
  - Any accepted done with core_valid=1 moves the FSM to SOLVED next cycle.
  - Sets solved=1, found_key=core_key[c], found_core=c.
  - If several cores report valid in the same cycle, the lowest index wins.
  - No further core_restart pulses are issued; later dones are ignored and keys_tried freezes.
- Exhaustion:
  - Condition: next_key > hi, all cores idle, and no valid done in that cycle.
  - Result: EXHAUSTED next cycle with exhausted=1.
- Simultaneous solve and exhaustion in the same cycle: solve wins.
- abort in any state:
  - Goes to IDLE next cycle and clears busy, solved, exhausted and busy flags.
  - abort and start in the same cycle: abort wins.
- busy=1 exactly while the FSM is in RUN.

Test Plan:
1. N_CORES=4, lo=0, hi=9; each core returns done (valid=0) 5 cycles after its restart.
   - Required: ten restart pulses with keys 0..9 in ascending order, first on core 0 at t+1.
   - Required: exhausted=1 after the last done, keys_tried=10, solved=0, busy=0.
2. lo=0x30, hi=0x50; the core holding key 0x3A reports valid.
   - Required: solved=1, found_key=0x3A, found_core equals that core's index.
   - Required: no restart pulses after the solve; keys_tried freezes.
3. Cores 1 and 3 report done with valid=1 in the same cycle.
   - Required: found_core=1, found_key=core 1's key.
4. lo=hi=0xFFFFFF.
   - Required: exactly one restart with key 0xFFFFFF and no wrap to 0.
   - Required: exhausted=1 and keys_tried=1 after the done.
5. lo=5, hi=4.
   - Required: exhausted=1 one cycle after start, with zero restart pulses.
6. Drive reset_n=0 mid-RUN, and separately pulse abort mid-RUN.
   - Reset: all outputs 0 on the next cycle.
   - abort: IDLE next cycle, busy=0; a spurious core_done afterwards changes nothing.
   - A subsequent start re-runs cleanly from lo.

Source files
------------

// File: rtl/rc4_keysearch_ctrl.sv
// rc4_keysearch_ctrl
// Hands out candidate RC4 keys from an inclusive range [key_lo, key_hi] to
// N_CORES decrypt pipelines. It reports the first key that decrypts to a
// valid message, or it reports that the range ran out.
//
//  state       | meaning
//  ------------+-------------------------------------------------------------
//  S_IDLE      | no search active; waits for start
//  S_RUN       | dispatching keys and collecting core results (busy=1)
//  S_SOLVED    | a core reported a valid decrypt; found_key/found_core held
//  S_EXHAUSTED | every key in range was tried, or lo>hi; nothing valid
module rc4_keysearch_ctrl #(
   parameter int KEY_W   = 24,
   parameter int N_CORES = 4,
   parameter int IDX_W   = 2
) (
   input  logic                       clk,
   input  logic                       reset_n,
   input  logic                       start,
   input  logic                       abort,
   input  logic [KEY_W-1:0]           key_lo,
   input  logic [KEY_W-1:0]           key_hi,
   output logic [N_CORES*KEY_W-1:0]   core_key,
   output logic [N_CORES-1:0]         core_restart,
   input  logic [N_CORES-1:0]         core_done,
   input  logic [N_CORES-1:0]         core_valid,
   output logic                       busy,
   output logic                       solved,
   output logic                       exhausted,
   output logic [KEY_W-1:0]           found_key,
   output logic [IDX_W-1:0]           found_core,
   output logic [KEY_W:0]             keys_tried
);

   localparam int CNT_W = KEY_W + 1;

   typedef enum logic [1:0] {
      S_IDLE      = 2'd0,
      S_RUN       = 2'd1,
      S_SOLVED    = 2'd2,
      S_EXHAUSTED = 2'd3
   } state_t;

   state_t               state;
   logic [KEY_W-1:0]     hi_r;
   // One bit wider than a key so that hi = all-ones ends the range instead of wrapping.
   logic [CNT_W-1:0]     next_key;
   logic [N_CORES-1:0]   core_busy;

   logic [N_CORES-1:0]   accepted;
   logic [N_CORES-1:0]   winners;
   logic [N_CORES-1:0]   dispatch;
   logic                 taken;
   logic                 win_any;
   logic [IDX_W-1:0]     win_idx;
   logic [KEY_W-1:0]     win_key;
   logic [CNT_W-1:0]     done_cnt;
   logic                 key_left;
   logic                 all_idle_after;

   // Per-cycle decode: accepted dones, lowest-index winner, next core to load.
   always_comb begin
      accepted = (state == S_RUN) ? (core_done & core_busy) : '0;
      winners  = accepted & core_valid;
      win_any  = |winners;
      win_idx  = '0;
      win_key  = '0;
      for (int c = N_CORES - 1; c >= 0; c--) begin
         if (winners[c]) begin
            win_idx = IDX_W'(c);
            win_key = core_key[c*KEY_W +: KEY_W];
         end
      end
      done_cnt = '0;
      for (int c = 0; c < N_CORES; c++) begin
         done_cnt = done_cnt + CNT_W'(accepted[c]);
      end
      key_left       = (next_key <= {1'b0, hi_r});
      all_idle_after = ((core_busy & ~accepted) == '0);
      // Look only at the registered busy flags. A core that finishes this
      // cycle can therefore be reloaded no earlier than the next cycle.
      dispatch = '0;
      taken    = 1'b0;
      for (int c = 0; c < N_CORES; c++) begin
         if (!core_busy[c] && !taken) begin
            dispatch[c] = 1'b1;
            taken       = 1'b1;
         end
      end
      if (!key_left) begin
         dispatch = '0;
      end
   end

   // Search sequencer: state, key dispatch, result capture. Every output is registered.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state        <= S_IDLE;
         hi_r         <= '0;
         next_key     <= '0;
         core_busy    <= '0;
         core_key     <= '0;
         core_restart <= '0;
         busy         <= 1'b0;
         solved       <= 1'b0;
         exhausted    <= 1'b0;
         found_key    <= '0;
         found_core   <= '0;
         keys_tried   <= '0;
      end else begin
         core_restart <= '0;
         if (abort) begin
            state     <= S_IDLE;
            busy      <= 1'b0;
            solved    <= 1'b0;
            exhausted <= 1'b0;
            core_busy <= '0;
         end else begin
            case (state)
               S_IDLE, S_SOLVED, S_EXHAUSTED: begin
                  if (start) begin
                     hi_r       <= key_hi;
                     solved     <= 1'b0;
                     exhausted  <= 1'b0;
                     keys_tried <= '0;
                     core_busy  <= '0;
                     if (key_lo > key_hi) begin
                        state     <= S_EXHAUSTED;
                        busy      <= 1'b0;
                        exhausted <= 1'b1;
                        next_key  <= {1'b0, key_lo};
                     end else begin
                        // Every core is idle at start, so the first key always
                        // goes to core 0. Loading it on this edge makes its
                        // restart pulse appear in the same cycle that busy rises.
                        state                <= S_RUN;
                        busy                 <= 1'b1;
                        core_restart[0]      <= 1'b1;
                        core_key[KEY_W-1:0]  <= key_lo;
                        core_busy            <= N_CORES'(1);
                        next_key             <= {1'b0, key_lo} + CNT_W'(1);
                     end
                  end
               end
               S_RUN: begin
                  keys_tried <= keys_tried + done_cnt;
                  if (win_any) begin
                     state      <= S_SOLVED;
                     busy       <= 1'b0;
                     solved     <= 1'b1;
                     found_key  <= win_key;
                     found_core <= win_idx;
                     core_busy  <= '0;
                  end else if (!key_left && all_idle_after) begin
                     state     <= S_EXHAUSTED;
                     busy      <= 1'b0;
                     exhausted <= 1'b1;
                     core_busy <= '0;
                  end else begin
                     core_busy <= (core_busy & ~accepted) | dispatch;
                     for (int c = 0; c < N_CORES; c++) begin
                        if (dispatch[c]) begin
                           core_restart[c]              <= 1'b1;
                           core_key[c*KEY_W +: KEY_W]   <= next_key[KEY_W-1:0];
                        end
                     end
                     if (|dispatch) begin
                        next_key <= next_key + CNT_W'(1);
                     end
                  end
               end
               default: begin
                  state <= S_IDLE;
                  busy  <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_rc4_keysearch_ctrl.sv
// Testbench for rc4_keysearch_ctrl. A small core model answers every restart
// after a per-core delay. Table-driven searches are followed by hand-written
// corner sequences.
module tb_rc4_keysearch_ctrl;

   localparam int KEY_W   = 24;
   localparam int N_CORES = 4;
   localparam int IDX_W   = 2;
   localparam int CNT_W   = KEY_W + 1;

   logic                       clk = 1'b0;
   logic                       reset_n;
   logic                       start;
   logic                       abort;
   logic [KEY_W-1:0]           key_lo;
   logic [KEY_W-1:0]           key_hi;
   logic [N_CORES*KEY_W-1:0]   core_key;
   logic [N_CORES-1:0]         core_restart;
   logic [N_CORES-1:0]         core_done;
   logic [N_CORES-1:0]         core_valid;
   logic                       busy;
   logic                       solved;
   logic                       exhausted;
   logic [KEY_W-1:0]           found_key;
   logic [IDX_W-1:0]           found_core;
   logic [KEY_W:0]             keys_tried;

   always #5 clk = ~clk;

   rc4_keysearch_ctrl #(.KEY_W(KEY_W), .N_CORES(N_CORES), .IDX_W(IDX_W)) dut (
      .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
      .key_lo(key_lo), .key_hi(key_hi), .core_key(core_key),
      .core_restart(core_restart), .core_done(core_done), .core_valid(core_valid),
      .busy(busy), .solved(solved), .exhausted(exhausted),
      .found_key(found_key), .found_core(found_core), .keys_tried(keys_tried)
   );

   int checks = 0;
   int errors = 0;

   // core model state
   int                 cnt[N_CORES];
   int                 delay[N_CORES];
   logic [N_CORES-1:0] mbusy;
   logic [KEY_W-1:0]   mkey[N_CORES];
   logic [N_CORES-1:0] force_valid;
   logic               has_target;
   logic [KEY_W-1:0]   target;
   int                 target_core;
   logic [CNT_W-1:0]   exp_next;
   int                 restarts;

   typedef struct {
      logic [KEY_W-1:0] lo;
      logic [KEY_W-1:0] hi;
      logic             has_t;
      logic [KEY_W-1:0] tgt;
      logic             exp_solved;
      logic             exp_exh;
      int               exp_tries;
      int               exp_restarts;
      int               exp_core;
   } vec_t;

   vec_t vecs[5];

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic model_clear();
      mbusy       = '0;
      core_done   = '0;
      core_valid  = '0;
      force_valid = '0;
      has_target  = 1'b0;
      for (int c = 0; c < N_CORES; c++) begin
         cnt[c]   = 0;
         delay[c] = 5;
         mkey[c]  = '0;
      end
   endtask

   // One clock: sample after the edge, score restarts, then advance the core model.
   task automatic step();
      @(posedge clk);
      #1;
      for (int c = 0; c < N_CORES; c++) begin
         if (core_restart[c]) begin
            check("restart_on_idle_core", mbusy[c], 1'b0);
            check("restart_key", core_key[c*KEY_W +: KEY_W], exp_next[KEY_W-1:0]);
            if (has_target && exp_next == {1'b0, target}) target_core = c;
            exp_next = exp_next + 1'b1;
            restarts++;
         end
      end
      for (int c = 0; c < N_CORES; c++) begin
         if (core_done[c]) mbusy[c] = 1'b0;
      end
      core_done  = '0;
      core_valid = '0;
      for (int c = 0; c < N_CORES; c++) begin
         if (core_restart[c]) begin
            mbusy[c] = 1'b1;
            cnt[c]   = delay[c];
            mkey[c]  = core_key[c*KEY_W +: KEY_W];
         end
      end
      for (int c = 0; c < N_CORES; c++) begin
         if (mbusy[c] && cnt[c] > 0) begin
            cnt[c]--;
            if (cnt[c] == 0) begin
               core_done[c]  = 1'b1;
               core_valid[c] = (has_target && mkey[c] == target) || force_valid[c];
            end
         end
      end
   endtask

   task automatic do_start(input logic [KEY_W-1:0] lo, input logic [KEY_W-1:0] hi);
      key_lo      = lo;
      key_hi      = hi;
      exp_next    = {1'b0, lo};
      restarts    = 0;
      target_core = -1;
      start       = 1'b1;
      step();
      start       = 1'b0;
   endtask

   task automatic wait_end(input int bound);
      int n;
      n = 0;
      while (!(solved || exhausted) && n < bound) begin
         step();
         n++;
      end
      check("search_end", solved | exhausted, 1'b1);
   endtask

   int tried_snap;
   int rs_snap;

   initial begin
      vecs[0] = '{lo: 24'h0,      hi: 24'h9,      has_t: 1'b0, tgt: 24'h0,
                  exp_solved: 1'b0, exp_exh: 1'b1, exp_tries: 10, exp_restarts: 10, exp_core: -1};
      vecs[1] = '{lo: 24'h30,     hi: 24'h50,     has_t: 1'b1, tgt: 24'h3A,
                  exp_solved: 1'b1, exp_exh: 1'b0, exp_tries: 11, exp_restarts: -1, exp_core: 2};
      vecs[2] = '{lo: 24'hFFFFFF, hi: 24'hFFFFFF, has_t: 1'b0, tgt: 24'h0,
                  exp_solved: 1'b0, exp_exh: 1'b1, exp_tries: 1, exp_restarts: 1, exp_core: -1};
      vecs[3] = '{lo: 24'h5,      hi: 24'h4,      has_t: 1'b0, tgt: 24'h0,
                  exp_solved: 1'b0, exp_exh: 1'b1, exp_tries: 0, exp_restarts: 0, exp_core: -1};
      vecs[4] = '{lo: 24'h20,     hi: 24'h22,     has_t: 1'b1, tgt: 24'h22,
                  exp_solved: 1'b1, exp_exh: 1'b0, exp_tries: 3, exp_restarts: 3, exp_core: 2};

      reset_n = 1'b0;
      start   = 1'b0;
      abort   = 1'b0;
      key_lo  = '0;
      key_hi  = '0;
      exp_next = '0;
      restarts = 0;
      target_core = -1;
      target  = '0;
      model_clear();
      step();
      step();
      check("rst_busy", busy, 1'b0);
      check("rst_core_key", core_key, '0);
      check("rst_keys_tried", keys_tried, '0);
      check("rst_flags", {solved, exhausted, core_restart}, '0);
      reset_n = 1'b1;
      step();

      for (int v = 0; v < 5; v++) begin
         model_clear();
         has_target = vecs[v].has_t;
         target     = vecs[v].tgt;
         do_start(vecs[v].lo, vecs[v].hi);
         check($sformatf("v%0d_first_restart", v), core_restart,
               (vecs[v].lo <= vecs[v].hi) ? 4'b0001 : 4'b0000);
         check($sformatf("v%0d_busy_after_start", v), busy, vecs[v].lo <= vecs[v].hi);
         if (vecs[v].lo > vecs[v].hi)
            check($sformatf("v%0d_exh_immediate", v), exhausted, 1'b1);
         wait_end(400);
         check($sformatf("v%0d_solved", v), solved, vecs[v].exp_solved);
         check($sformatf("v%0d_exhausted", v), exhausted, vecs[v].exp_exh);
         check($sformatf("v%0d_busy_end", v), busy, 1'b0);
         if (vecs[v].exp_tries >= 0)
            check($sformatf("v%0d_keys_tried", v), keys_tried, vecs[v].exp_tries);
         if (vecs[v].exp_solved) begin
            check($sformatf("v%0d_found_key", v), found_key, vecs[v].tgt);
            check($sformatf("v%0d_found_core", v), found_core, vecs[v].exp_core);
            check($sformatf("v%0d_found_core_holder", v), found_core, target_core);
         end
         tried_snap = keys_tried;
         rs_snap    = restarts;
         for (int i = 0; i < 12; i++) step();
         if (vecs[v].exp_restarts >= 0)
            check($sformatf("v%0d_restarts", v), restarts, vecs[v].exp_restarts);
         check($sformatf("v%0d_no_restart_after_end", v), restarts, rs_snap);
         check($sformatf("v%0d_tries_frozen", v), keys_tried, tried_snap);
         check($sformatf("v%0d_sticky", v), {solved, exhausted},
               {vecs[v].exp_solved, vecs[v].exp_exh});
      end

      // Cores 1 and 3 report valid in the same cycle; the lower index must win.
      model_clear();
      delay[0] = 0;
      delay[1] = 7;
      delay[2] = 0;
      delay[3] = 5;
      force_valid = 4'b1010;
      do_start(24'h100, 24'h1FF);
      wait_end(100);
      check("tie_solved", solved, 1'b1);
      check("tie_found_core", found_core, 2'd1);
      check("tie_found_key", found_key, 24'h101);
      check("tie_keys_tried", keys_tried, 2);

      // Reset in the middle of a run clears every output on the next cycle.
      step();
      model_clear();
      do_start(24'h0, 24'd100);
      for (int i = 0; i < 10; i++) step();
      check("pre_reset_busy", busy, 1'b1);
      reset_n = 1'b0;
      step();
      check("midrst_core_key", core_key, '0);
      check("midrst_restart", core_restart, '0);
      check("midrst_flags", {busy, solved, exhausted}, 3'b000);
      check("midrst_found", {found_key, found_core}, '0);
      check("midrst_keys_tried", keys_tried, '0);
      reset_n = 1'b1;
      model_clear();
      step();

      // Abort in the middle of a run; start during RUN is ignored; a spurious done is ignored.
      do_start(24'h10, 24'h80);
      for (int i = 0; i < 4; i++) step();
      key_lo = 24'h70;
      key_hi = 24'h75;
      start  = 1'b1;
      step();
      start  = 1'b0;
      for (int i = 0; i < 3; i++) step();
      check("run_ignores_start_busy", busy, 1'b1);
      abort = 1'b1;
      step();
      abort = 1'b0;
      check("abort_busy", busy, 1'b0);
      check("abort_flags", {solved, exhausted}, 2'b00);
      model_clear();
      tried_snap = keys_tried;
      rs_snap    = restarts;
      core_done  = 4'b1111;
      core_valid = 4'b1111;
      step();
      step();
      step();
      check("spurious_solved", solved, 1'b0);
      check("spurious_busy", busy, 1'b0);
      check("spurious_tries", keys_tried, tried_snap);
      check("spurious_restarts", restarts, rs_snap);

      model_clear();
      do_start(24'h20, 24'h23);
      check("rerun_first_restart", core_restart, 4'b0001);
      check("rerun_first_key", core_key[KEY_W-1:0], 24'h20);
      wait_end(100);
      check("rerun_exhausted", exhausted, 1'b1);
      check("rerun_keys_tried", keys_tried, 4);
      check("rerun_restarts", restarts, 4);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
